// File: rtl/bcd_down_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_counter_if
//  Description : Signal bundle for the cascadable BCD down counter.
//                The master drives the load value and the control strobes.
//                The slave (the counter) returns the count, the zero flag,
//                borrow-out and the registered underflow pulse.
//
//                Ports carried (widths for DIGITS digits):
//                  D    [4*DIGITS-1:0]  parallel load / reload value
//                  CS                   synchronous clear
//                  LD                   synchronous parallel load
//                  EN                   count enable
//                  BI                   borrow-in
//                  Q    [4*DIGITS-1:0]  registered count
//                  BO                   borrow-out, BI && EN && ZERO
//                  ZERO                 Q == 0
//                  TCQ                  registered underflow pulse
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_down_counter_if #(
    parameter int DIGITS = 2
);
    logic [4*DIGITS-1:0] D;
    logic                CS;
    logic                LD;
    logic                EN;
    logic                BI;
    logic [4*DIGITS-1:0] Q;
    logic                BO;
    logic                ZERO;
    logic                TCQ;

    modport master (
        output D, CS, LD, EN, BI,
        input  Q, BO, ZERO, TCQ
    );

    modport slave (
        input  D, CS, LD, EN, BI,
        output Q, BO, ZERO, TCQ
    );
endinterface
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_counter
//  Description : Cascadable N-digit BCD (decade) down counter with
//                synchronous clear, parallel load, count enable, borrow-in
//                and combinational borrow-out. Optional auto-reload from D
//                on underflow turns it into a divide-by-(D+1) prescaler.
//
//  Parameters  : DIGITS      number of BCD digits (1..8)
//                AUTO_RELOAD 0: underflow wraps to all 9s
//                            1: underflow reloads D
//
//  Ports       : CLK   rising-edge clock
//                CDN   asynchronous active-low clear
//                bus   slave side of bcd_down_counter_if
//                      (D, CS, LD, EN, BI in; Q, BO, ZERO, TCQ out)
//
//  Priority at each clock edge: CS > LD > count (BI && EN) > hold.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_down_counter #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic               CLK,
    input  logic               CDN,
    bcd_down_counter_if.slave  bus
);

    localparam int         c_width = 4 * DIGITS;
    localparam logic [3:0] c_nine  = 4'd9;

    logic [c_width-1:0] r_q;
    logic               r_tcq;

    logic [c_width-1:0] w_dec;        // Q after one BCD decrement
    logic [c_width-1:0] w_uf_value;   // value taken on underflow
    logic [DIGITS-1:0]  w_borrow;     // borrow arriving at each digit
    logic [DIGITS-1:0]  w_dig_zero;   // digit currently reads 0
    logic               w_zero;
    logic               w_count;

    assign w_zero  = (r_q == '0);
    assign w_count = bus.BI & bus.EN;

    // ------------------------------------------------------------------
    // Per-digit decrement. Each nibble is handled on its own; there is no
    // binary carry across digit boundaries. A borrow ripples upward only
    // through digits that read 0. An invalid nibble (A..F) that receives a
    // borrow is forced to 9 and absorbs the borrow, so the counter heals
    // itself after a load of non-BCD data.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [3:0] w_cur;
        logic [3:0] w_nxt;

        assign w_cur         = r_q[4*k +: 4];
        assign w_dig_zero[k] = (w_cur == 4'd0);

        if (k == 0) begin : g_lsd
            assign w_borrow[k] = 1'b1;
        end else begin : g_upper
            assign w_borrow[k] = w_borrow[k-1] & w_dig_zero[k-1];
        end

        always_comb begin
            w_nxt = w_cur;
            if (w_borrow[k]) begin
                if ((w_cur == 4'd0) || (w_cur > c_nine)) begin
                    w_nxt = c_nine;
                end else begin
                    w_nxt = w_cur - 4'd1;
                end
            end
        end

        assign w_dec[4*k +: 4] = w_nxt;
    end

    // ------------------------------------------------------------------
    // Underflow value. Decrementing all zeros through the digit chain
    // already yields all 9s, so the wrap mode simply reuses w_dec.
    // ------------------------------------------------------------------
    if (AUTO_RELOAD) begin : g_reload
        assign w_uf_value = bus.D;
    end else begin : g_wrap
        assign w_uf_value = w_dec;
    end

    // ------------------------------------------------------------------
    // Count and underflow registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            r_q   <= '0;
            r_tcq <= 1'b0;
        end else if (bus.CS) begin
            r_q   <= '0;
            r_tcq <= 1'b0;
        end else if (bus.LD) begin
            r_q   <= bus.D;
            r_tcq <= 1'b0;
        end else if (w_count) begin
            r_q   <= w_zero ? w_uf_value : w_dec;
            r_tcq <= w_zero;
        end else begin
            r_tcq <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. BO is combinational and deliberately ignores CS/LD so that
    // a chain of instances sees the borrow in the same cycle.
    // ------------------------------------------------------------------
    assign bus.Q    = r_q;
    assign bus.TCQ  = r_tcq;
    assign bus.ZERO = w_zero;
    assign bus.BO   = w_count & w_zero;

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_down_counter
//  Description : Self-checking bench for bcd_down_counter. One shared
//                stimulus drives a 2-digit wrap counter, a 2-digit reload
//                counter and a cascade of two 1-digit counters. A decimal
//                reference model predicts every output each cycle; directed
//                sequences pin the model against literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_down_counter;

    logic       clk = 1'b0;
    logic       cdn;
    logic       cs, ld, en, bi;
    logic [7:0] d;
    logic       chk_on;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    bcd_down_counter_if #(.DIGITS(2)) if_w  ();
    bcd_down_counter_if #(.DIGITS(2)) if_r  ();
    bcd_down_counter_if #(.DIGITS(1)) if_lo ();
    bcd_down_counter_if #(.DIGITS(1)) if_hi ();

    assign if_w.D  = d;  assign if_w.CS  = cs; assign if_w.LD  = ld;
    assign if_w.EN = en; assign if_w.BI  = bi;
    assign if_r.D  = d;  assign if_r.CS  = cs; assign if_r.LD  = ld;
    assign if_r.EN = en; assign if_r.BI  = bi;
    assign if_lo.D  = d[3:0]; assign if_lo.CS = cs; assign if_lo.LD = ld;
    assign if_lo.EN = en;     assign if_lo.BI = bi;
    assign if_hi.D  = d[7:4]; assign if_hi.CS = cs; assign if_hi.LD = ld;
    assign if_hi.EN = en;     assign if_hi.BI = if_lo.BO;

    bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b0)) u_wrap (
        .CLK(clk), .CDN(cdn), .bus(if_w));
    bcd_down_counter #(.DIGITS(2), .AUTO_RELOAD(1'b1)) u_reload (
        .CLK(clk), .CDN(cdn), .bus(if_r));
    bcd_down_counter #(.DIGITS(1), .AUTO_RELOAD(1'b0)) u_lo (
        .CLK(clk), .CDN(cdn), .bus(if_lo));
    bcd_down_counter #(.DIGITS(1), .AUTO_RELOAD(1'b0)) u_hi (
        .CLK(clk), .CDN(cdn), .bus(if_hi));

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] dec2(input logic [7:0] q);
        int         v;
        logic [7:0] r;
        logic [3:0] dg;
        bit         b;
        if (q[7:4] <= 4'd9 && q[3:0] <= 4'd9) begin
            v = int'(q[7:4]) * 10 + int'(q[3:0]);
            v = (v + 99) % 100;
            return {4'(v / 10), 4'(v % 10)};
        end
        r = q;
        b = 1'b1;
        for (int k = 0; k < 2; k++) begin
            dg = q[4*k +: 4];
            if (b) begin
                if (dg == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else if (dg > 4'd9) begin
                    r[4*k +: 4] = 4'd9;
                    b = 1'b0;
                end else begin
                    r[4*k +: 4] = dg - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [7:0] m0, m1;   // wrap model, reload model
    logic       t0, t1;

    always @(posedge clk or negedge cdn) begin
        if (!cdn) begin
            m0 <= 8'h00; m1 <= 8'h00; t0 <= 1'b0; t1 <= 1'b0;
        end else if (cs) begin
            m0 <= 8'h00; m1 <= 8'h00; t0 <= 1'b0; t1 <= 1'b0;
        end else if (ld) begin
            m0 <= d; m1 <= d; t0 <= 1'b0; t1 <= 1'b0;
        end else if (en && bi) begin
            m0 <= dec2(m0);
            t0 <= (m0 == 8'h00);
            m1 <= (m1 == 8'h00) ? d : dec2(m1);
            t1 <= (m1 == 8'h00);
        end else begin
            t0 <= 1'b0; t1 <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Compare process: every negedge while enabled
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("w_q",     32'(if_w.Q),    32'(m0));
            chk("w_tcq",   32'(if_w.TCQ),  32'(t0));
            chk("w_zero",  32'(if_w.ZERO), 32'(m0 == 8'h00));
            chk("w_bo",    32'(if_w.BO),   32'(en && bi && m0 == 8'h00));
            chk("r_q",     32'(if_r.Q),    32'(m1));
            chk("r_tcq",   32'(if_r.TCQ),  32'(t1));
            chk("r_bo",    32'(if_r.BO),   32'(en && bi && m1 == 8'h00));
            chk("c_q",     32'({if_hi.Q, if_lo.Q}), 32'(m0));
            chk("c_bo",    32'(if_hi.BO),  32'(en && bi && m0 == 8'h00));
            chk("c_tcq",   32'(if_hi.TCQ), 32'(t0));
            chk("c_lo_zero", 32'(if_lo.ZERO), 32'(m0[3:0] == 4'h0));
        end
    end

    // Apply one set of controls, let one edge consume them, return 2 time
    // units after the edge.
    task automatic cyc(input logic i_cs, input logic i_ld, input logic i_en,
                       input logic i_bi, input logic [7:0] i_d);
        cs = i_cs; ld = i_ld; en = i_en; bi = i_bi; d = i_d;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] exp_wrap [11] = '{8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
                                  8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
    logic [7:0] exp_rl   [12] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h04, 8'h03,
                                  8'h02, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02};

    initial begin
        int  ntcq;
        logic p_cs, p_ld, p_en, p_bi;
        logic [7:0] p_d;

        cdn = 1'b0; cs = 1'b0; ld = 1'b0; en = 1'b0; bi = 1'b0; d = 8'h00;
        chk_on = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_q",    32'(if_w.Q),    32'h00);
        chk("reset_zero", 32'(if_w.ZERO), 32'h1);
        chk("reset_tcq",  32'(if_w.TCQ),  32'h0);
        cdn    = 1'b1;
        chk_on = 1'b1;

        // asynchronous clear from a loaded value
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h57);
        chk("load57", 32'(if_w.Q), 32'h57);
        cdn = 1'b0;
        #1;
        chk("async_q",   32'(if_w.Q),   32'h00);
        chk("async_tcq", 32'(if_w.TCQ), 32'h0);
        cdn = 1'b1;

        // hold with EN low
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("hold_q",    32'(if_w.Q),    32'h00);
        chk("hold_zero", 32'(if_w.ZERO), 32'h1);
        chk("hold_bo",   32'(if_w.BO),   32'h0);

        // countdown from 10 through wrap
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        chk("load10_model", 32'(m0), 32'h10);
        chk("load10_casc",  32'({if_hi.Q, if_lo.Q}), 32'h10);
        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h10);
            chk("wrap_model", 32'(m0),        32'(exp_wrap[i]));
            chk("wrap_q",     32'(if_w.Q),    32'(exp_wrap[i]));
            chk("wrap_tcq",   32'(if_w.TCQ),  32'(exp_wrap[i] == 8'h99));
            chk("wrap_bo",    32'(if_w.BO),   32'(exp_wrap[i] == 8'h00));
            chk("casc_q",     32'({if_hi.Q, if_lo.Q}), 32'(exp_wrap[i]));
            chk("casc_bo",    32'(if_hi.BO),  32'(exp_wrap[i] == 8'h00));
        end

        // reload divider
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h04);
        ntcq = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
            chk("reload_q",     32'(if_r.Q), 32'(exp_rl[i]));
            chk("reload_model", 32'(m1),     32'(exp_rl[i]));
            if (if_r.TCQ) ntcq++;
        end
        chk("reload_tcq_count", 32'(ntcq), 32'd2);

        // priority
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h35);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h72);
        chk("prio_clear", 32'(if_w.Q), 32'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h72);
        chk("prio_load",     32'(if_w.Q),   32'h72);
        chk("prio_load_tcq", 32'(if_w.TCQ), 32'h0);

        // invalid digits
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
        chk("inv_3c", 32'(if_w.Q), 32'h39);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hA0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hA0);
        chk("inv_a0",     32'(if_w.Q),   32'h99);
        chk("inv_a0_tcq", 32'(if_w.TCQ), 32'h0);
        chk("inv_a0_model", 32'(m0),     32'h99);

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            p_cs = ($urandom_range(0, 99) < 3);
            p_ld = ($urandom_range(0, 99) < 5);
            p_en = ($urandom_range(0, 99) < 80);
            p_bi = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 70)
                p_d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                p_d = 8'($urandom);
            cs = p_cs; ld = p_ld; en = p_en; bi = p_bi; d = p_d;
            if ($urandom_range(0, 199) == 0) begin
                cdn = 1'b0;
                #1;
                cdn = 1'b1;
            end
            @(posedge clk);
            #2;
        end

        chk_on = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Cascadable N-digit BCD (decade) down counter: synchronous clear, parallel load, enable, borrow-in (BI) and borrow-out (BO).
- Counterpart of the macro library's decade up counters. Used for countdown timers and programmable dividers.
- Multiple instances chain BO to the next instance's BI, least significant first.
- Optional auto-reload from D on underflow turns the block into a divide-by-(D+1) prescaler.

Parameters:
DIGITS, 2, number of BCD digits (1..8); Q/D width is 4*DIGITS
AUTO_RELOAD, 0, 0: underflow wraps to all-9s; 1: underflow reloads D

Ports:
CLK  input  1  rising-edge clock
CDN  input  1  asynchronous active-low reset (clear)
D    input  4*DIGITS  parallel load / reload value, digit k in bits [4k+3:4k]
CS   input  1  synchronous clear, highest synchronous priority
LD   input  1  synchronous parallel load
EN   input  1  count enable
BI   input  1  borrow-in; count occurs only when BI && EN
Q    output 4*DIGITS  counter value, registered
BO   output 1  borrow-out (combinational), BI && EN && ZERO
ZERO output 1  combinational, Q == 0
TCQ  output 1  registered underflow pulse

Behaviour:
- Reset and clock:
  - CDN low, asynchronous: Q = 0, TCQ = 0 immediately, held while CDN is low.
  - Deassertion of CDN is synchronised externally. The block does no reset synchronisation.
- Priority at each CLK rise (CDN high): CS > LD > count > hold.
  - CS=1: Q <= 0, TCQ <= 0.
  - else LD=1: Q <= D exactly as presented, including non-BCD nibbles A-F. TCQ <= 0.
  - else BI && EN: decrement (rules below).
  - else: Q holds, TCQ <= 0.
- Decrement, per digit k (ripple within one cycle):
  - Digit 0 always receives the borrow. Digit k>0 receives a borrow only if digit k-1 receives one and digit k-1 was 0.
  - A digit receiving a borrow:
    - 1..9: minus 1.
    - 0: becomes 9 and passes the borrow on.
    - A..F (invalid): forced to 9, no borrow passed on (self-correction).
  - A digit not receiving a borrow holds.
- Underflow: a count cycle with Q == 0 at the clock edge.
  - AUTO_RELOAD=0: Q <= all digits 9 (e.g. 8'h99 for DIGITS=2).
  - AUTO_RELOAD=1: Q <= D.
  - Both modes: TCQ <= 1 for exactly one cycle. Any non-underflow edge clears TCQ.
- Zero and borrow-out:
  - ZERO = (Q == 0). BO = BI && EN && ZERO, purely combinational, no added latency. This allows same-cycle cascading.
  - BO is not gated by CS or LD; it reflects current Q and the enables only.
- Latency: Q changes one clock after sampled controls. TCQ asserts in the same edge that produces the underflow value.
- Simultaneous events:
  - CS with LD/count: clear wins. BO may still be 1 that cycle if Q == 0.
  - LD with count: load wins, no decrement, TCQ = 0.
  - CDN asserted mid-count overrides everything asynchronously.
- Reset state: ZERO = 1. BO = BI && EN.
- Width rule: no binary arithmetic across digit boundaries. Each nibble is handled independently, so Q never holds a value whose digits exceed 9 except via LD.

Test Plan:
- Reset/hold: CDN=0 while Q=8'h57 -> Q=8'h00 and TCQ=0 asynchronously. CDN=1, EN=0 for 5 clocks -> Q stays 8'h00, ZERO=1, BO=0.
- Countdown and wrap (DIGITS=2, AUTO_RELOAD=0):
  - LD D=8'h10, then BI=EN=1 -> Q: 10, 09, 08 ... 01, 00, 99.
  - BO=1 only in the cycle Q=00. TCQ=1 only in the cycle Q=99.
- Reload divider (AUTO_RELOAD=1): D=8'h04, LD, then BI=EN=1 for 12 clocks -> Q: 04,03,02,01,00,04,03,... TCQ pulses once every 5 clocks.
- Priority:
  - Q=8'h35, CS=LD=EN=BI=1 -> Q=8'h00.
  - Next edge, LD=1, EN=BI=1, D=8'h72 -> Q=8'h72, no decrement, TCQ=0.
- Invalid digits: LD D=8'h3C, count -> Q=8'h39. LD D=8'hA0, count -> Q=8'h99, TCQ=0 (not an underflow).
- Cascade: two DIGITS=1 instances, low BO -> high BI, both EN=1, loaded 1 and 0 -> combined 10, 09 ... 00, 99. High-instance BO=1 only while combined value is 00.
